// File: rtl/conv_frame_sequencer_if.sv
// Frame-RAM and filter-stream bundle for the convolution frame sequencer.
// Latency: none, wires only. Backpressure: x_ready/y_ready carried as plain handshake bits.
// Ports: input-RAM read (rd_*), filter input (x_*), filter output (y_*), output-RAM write (wr_*).
interface conv_frame_sequencer_if #(
    parameter int W      = 8,
    parameter int ADDR_W = 19
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_data;
    logic              x_valid;
    logic              x_ready;
    logic [W-1:0]      x_data;
    logic              y_valid;
    logic              y_ready;
    logic [W-1:0]      y_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_data;

    // master = sequencer side, slave = RAMs + filter side
    modport master (
        output rd_en, rd_addr, input rd_data,
        output x_valid, x_data, input x_ready,
        input y_valid, y_data, output y_ready,
        output wr_en, wr_addr, wr_data
    );
    modport slave (
        input rd_en, rd_addr, output rd_data,
        input x_valid, x_data, output x_ready,
        output y_valid, y_data, input y_ready,
        input wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame controller: latches a kernel, streams a frame from RAM into the 3x3 filter, stores its output.
// Latency: 2 cycles from rd_en to x_valid; output beats written to RAM in the cycle they arrive.
// Backpressure: x_ready stalls reads via a 2-entry buffer; y_ready is high whenever busy (never stalls filter).
// Ports: clk/rst, start/kernel_sel/custom_kernel in; kernel_flat, busy, done, timeout, overrun,
//        in_count, out_count out; RAM and filter streams through the bus interface.
module conv_frame_sequencer #(
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int W             = 8,
    parameter int ADDR_W        = 19,
    parameter int DRAIN_TIMEOUT = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           kernel_sel,
    input  logic [9*W-1:0]       custom_kernel,
    output logic [9*W-1:0]       kernel_flat,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 overrun,
    output logic [ADDR_W:0]      in_count,
    output logic [ADDR_W:0]      out_count,
    conv_frame_sequencer_if.master bus
);
    localparam int              N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int              CW    = ADDR_W + 1;
    localparam logic [CW-1:0]   N_C   = CW'(N);
    localparam int              TW    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_C = TW'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] rd_ptr;
    logic [W-1:0]  buf0, buf1;      // buf0 is the head presented on x_data
    logic [1:0]    occ;
    logic          inflight;        // a read issued last cycle lands this cycle
    logic [TW-1:0] timer;
    logic          start_ok, x_acc, y_acc, wr_ok, rd_go, drain_full, timer_exp;
    logic [CW-1:0] out_count_nxt;

    function automatic logic [9*W-1:0] kernel_for(input logic [1:0] sel,
                                                  input logic [9*W-1:0] custom);
        logic [9*W-1:0] kf;
        int             c;
        kf = custom;
        if (sel != 2'd3) begin
            for (int i = 0; i < 9; i++) begin
                case (sel)
                    2'd0:    c = 1;
                    2'd1:    c = (i == 4) ? 5 : ((i % 2 == 1) ? -1 : 0);
                    default: c = (i == 4) ? 8 : -1;
                endcase
                kf[i*W +: W] = c[W-1:0];
            end
        end
        return kf;
    endfunction

    assign start_ok      = (state == S_IDLE) && start;
    assign busy          = (state == S_RUN) || (state == S_DRAIN);
    assign done          = (state == S_DONE);

    assign bus.x_valid   = (occ != 2'd0);
    assign bus.x_data    = buf0;
    assign x_acc         = bus.x_valid && bus.x_ready;

    assign bus.y_ready   = busy;
    assign y_acc         = bus.y_valid && busy;
    assign wr_ok         = y_acc && (out_count < N_C);
    assign bus.wr_en     = wr_ok;
    assign bus.wr_addr   = out_count[ADDR_W-1:0];
    assign bus.wr_data   = bus.y_data;
    assign out_count_nxt = out_count + CW'(wr_ok);

    // Credit check counts the slot freed by this cycle's acceptance so a
    // continuously ready filter sees one pixel per cycle.
    assign rd_go = (state == S_RUN) && (rd_ptr < N_C) &&
                   (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, x_acc}));
    assign bus.rd_en   = rd_go;
    assign bus.rd_addr = rd_ptr[ADDR_W-1:0];

    // Completion is judged on the post-write count so it beats a same-cycle expiry.
    assign drain_full = (out_count_nxt == N_C);
    assign timer_exp  = (state == S_DRAIN) && !drain_full && (timer == TMO_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (in_count == N_C) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_full || timer_exp) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kernel_flat <= '0;
            in_count    <= '0;
            out_count   <= '0;
            rd_ptr      <= '0;
            timer       <= '0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
            occ         <= 2'd0;
            inflight    <= 1'b0;
            buf0        <= '0;
            buf1        <= '0;
        end else if (start_ok) begin
            kernel_flat <= kernel_for(kernel_sel, custom_kernel);
            in_count    <= '0;
            out_count   <= '0;
            rd_ptr      <= '0;
            timer       <= '0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
            occ         <= 2'd0;
            inflight    <= 1'b0;
        end else begin
            inflight <= rd_go;
            if (rd_go) rd_ptr <= rd_ptr + 1'b1;
            if (x_acc) begin
                buf0     <= buf1;
                in_count <= in_count + 1'b1;
            end
            // Returning data goes into the first slot free after this cycle's pop.
            if (inflight) begin
                if (occ == 2'd0 || (occ == 2'd1 && x_acc)) buf0 <= bus.rd_data;
                else                                         buf1 <= bus.rd_data;
            end
            occ       <= occ + {1'b0, inflight} - {1'b0, x_acc};
            out_count <= out_count_nxt;
            if (y_acc && !wr_ok) overrun <= 1'b1;
            if (state == S_DRAIN) timer <= wr_ok ? '0 : timer + 1'b1;
            if (timer_exp) timeout <= 1'b1;
        end
    end
endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller for the streaming 3x3 convolution filter.
- Latches a kernel (preset or custom) at frame start and reads the input frame from a synchronous frame-buffer RAM.
- Streams pixels into the filter's valid/ready input, captures the filter output stream into an output RAM, and reports done/timeout.
- Sits between the frame buffers and the convolution filter in the pattern-recognition path.

Parameters:
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame; N = IMG_WIDTH*IMG_HEIGHT
- W, 8, pixel and kernel-coefficient width
- ADDR_W, 19, RAM address width (must satisfy 2^ADDR_W >= N)
- DRAIN_TIMEOUT, 500000, idle cycles allowed in DRAIN before abort

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame
- kernel_sel  in  2  0=box blur, 1=sharpen, 2=edge, 3=custom
- custom_kernel  in  9*W  signed coefficients, row-major; [W-1:0] is k[0][0]
- kernel_flat  out  9*W  kernel driven to filter, same packing
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at frame end
- timeout  out  1  sticky; DRAIN expired; cleared by start
- overrun  out  1  sticky; output beat arrived after N; cleared by start
- rd_en  out  1  input RAM read strobe
- rd_addr  out  ADDR_W  input RAM address
- rd_data  in  W  valid exactly 1 cycle after rd_en
- x_valid  out  1  to filter
- x_ready  in  1  from filter
- x_data  out  W  to filter
- y_valid  in  1  from filter
- y_ready  out  1  to filter
- y_data  in  W  from filter
- wr_en  out  1  output RAM write strobe
- wr_addr  out  ADDR_W  output RAM address
- wr_data  out  W  output RAM data
- in_count  out  ADDR_W+1  pixels accepted by filter
- out_count  out  ADDR_W+1  pixels written

Behaviour:
- Reset values: all outputs 0, kernel_flat 0, state IDLE. A reset mid-frame aborts the frame immediately; no done pulse is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start:
  - latch kernel_flat (presets box = all +1; sharpen = 0,-1,0/-1,5,-1/0,-1,0; edge = all -1 with centre +8; custom = custom_kernel);
  - zero in_count, out_count, read pointer and the drain timer;
  - clear timeout and overrun.
- kernel_flat is held constant from that point until the next accepted start. start is ignored outside IDLE.
- RUN, input side:
  - 2-entry pixel buffer feeds x_valid/x_data. x_valid = buffer not empty; x_data = buffer head.
  - Issue rd_en (rd_addr = read pointer, then increment) when read pointer < N and (occupancy + reads in flight) < 2. rd_data is pushed 1 cycle later.
  - Sustained rate is 1 pixel/cycle when x_ready stays high.
  - x_valid/x_data hold stable while x_valid && !x_ready.
  - in_count increments on each x_valid && x_ready.
- Output side (RUN and DRAIN):
  - y_ready = 1.
  - On y_valid: if out_count < N, assert wr_en = 1 combinationally with wr_addr = out_count and wr_data = y_data, then increment out_count. Otherwise drop the beat and set overrun.
- RUN -> DRAIN when in_count reaches N (buffer empty; x_valid = 0).
- DRAIN:
  - timer increments each cycle with no accepted output and resets on each accepted output;
  - out_count == N -> DONE;
  - timer == DRAIN_TIMEOUT -> set timeout, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. Counts hold their final values until the next start.
- Simultaneous events:
  - the last input acceptance and an output write in the same cycle are both counted;
  - if out_count reaches N in RUN before in_count does, stay in RUN and continue input;
  - if out_count reaches N and the timer expires in the same cycle, completion wins (timeout stays 0).
- Coefficient arithmetic: none; kernels are sign-extended W-bit constants.

Test Plan:
- 4x3 frame, kernel_sel=2, x_ready=1, filter model echoes with latency 5 -> kernel_flat = 8 at centre and -1 elsewhere; 12 rd_en, 12 writes at addresses 0..11 with echoed data; done pulses once; busy low afterwards.
- Same frame, x_ready toggling 1/0 each cycle -> no pixel lost or duplicated; x_data stable during stalls; in_count = 12; output RAM matches the input RAM.
- Filter emits only 10 outputs, DRAIN_TIMEOUT=20 -> timeout=1 exactly 20 idle cycles after the 10th output; done pulses; out_count = 10.
- Filter emits 13 outputs -> 12 writes only; overrun=1; the 13th beat is not written.
- start asserted while busy, with kernel_sel changed -> ignored; kernel_flat unchanged. rst asserted mid-RUN -> all outputs 0 asynchronously; the next start runs a clean frame.
- kernel_sel=3 with custom_kernel = 9 distinct values -> kernel_flat equals custom_kernel for the whole frame even if custom_kernel changes mid-frame.
